pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives stall and enable signals for the F, D, E and M stage registers, and the synchronous flushes of the D and E stage registers. It also drives the bypass selects for the D and E stages.
It owns a small state machine that freezes the whole pipeline while a multi-cycle data-memory access is outstanding. A watchdog bounds that wait.
Saturating performance counters record stall and flush cycles.

Parameters:
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before the access is abandoned and MemErr is set.
CNT_W, 32, width of the StallCnt and FlushCnt counters.

Ports:
CLK  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
RsD, RtD  input  5 each  D-stage source register numbers
RsE, RtE  input  5 each  E-stage source register numbers
WriteRegE, WriteRegM, WriteRegW  input  5 each  destination register number per stage
RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enable per stage
MemtoRegE, MemtoRegM  input  1 each  load in E / M
MemWriteM  input  1  store in M
BranchD, PCSrcD, JumpD  input  1 each  branch decoded / branch taken / jump in D
DmemReadyM  input  1  data memory completes the access this cycle
CntClr  input  1  synchronous clear of both counters
StallF, StallD, StallE, StallM  output  1 each  hold the corresponding stage register
FlushD  output  1  synchronous clear of the IF/ID register
FlushE  output  1  drives CLR_sync of the ID/EX register (bubble)
FlushW  output  1  inserts a bubble into MEM/WB
ForwardAD, ForwardBD  output  1 each  D-stage bypass from M
ForwardAE, ForwardBE  output  2 each  E-stage select: 00 register file, 01 W, 10 M
MemErr  output  1  sticky flag: memory timeout occurred
StallCnt, FlushCnt  output  CNT_W each  performance counters

Behaviour:
- reset low: state=RUN, wait counter=0, MemErr=0, StallCnt=0, FlushCnt=0.
- While reset is low, every stall, flush and forward output is 0. These outputs are combinational from inputs and state.
- Register 0 never causes a hazard and is never a forward source.
- Forwarding:
  - ForwardAE=10 if RegWriteM && WriteRegM==RsE; else 01 if RegWriteW && WriteRegW==RsE; else 00. M has priority over W.
  - ForwardBE is the same with RtE.
  - ForwardAD = RegWriteM && WriteRegM==RsD. ForwardBD is the same with RtD.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- memstall = (state==RUN && (MemtoRegM||MemWriteM) && !DmemReadyM) || (state==MEM_WAIT && !DmemReadyM && waitcnt<MEM_TIMEOUT).
- Output priority, highest first:
  - memstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=0, FlushE=0. The pipeline is frozen, so no flush is allowed.
  - lwstall||brstall: StallF=StallD=1, FlushE=1, FlushD=0, StallE=StallM=FlushW=0.
  - PCSrcD||JumpD: FlushD=1, all other controls 0.
  - otherwise all stall/flush outputs are 0.
- FSM, two states:
  - RUN -> MEM_WAIT when (MemtoRegM||MemWriteM) && !DmemReadyM. waitcnt is loaded with 1.
  - MEM_WAIT, DmemReadyM=1: -> RUN that same cycle; no stall that cycle; waitcnt=0.
  - MEM_WAIT, !DmemReadyM and waitcnt<MEM_TIMEOUT: stay; waitcnt+1.
  - MEM_WAIT, !DmemReadyM and waitcnt==MEM_TIMEOUT: -> RUN, MemErr<=1, waitcnt=0. The stall is released that cycle and the access is abandoned.
- Zero-wait access (DmemReadyM=1 in RUN) causes no stall and no state change.
- Back-to-back memory accesses each re-enter MEM_WAIT independently.
- MemErr stays set until reset.
- Counters:
  - StallCnt increments on every cycle with StallF=1.
  - FlushCnt increments on every cycle with FlushD||FlushE.
  - Both saturate at all-ones.
  - CntClr has priority over increment; the counter reads 0 next cycle.
- Reset asserted mid-MEM_WAIT returns the block to RUN immediately (asynchronous).

Decomposition:
- Shared package: forward-select encodings (FWD_RF=00, FWD_W=01, FWD_M=10), FSM state encoding (RUN, MEM_WAIT), register-0 constant.
- One sub-module, sat_counter (width parameter, inc, clr), instantiated twice for StallCnt and FlushCnt.
- Forwarding and hazard detection stay inline.

Test Plan:
- lw $2 in E (MemtoRegE=1, RtE=2), RsD=2 -> one cycle of StallF=StallD=1, FlushE=1; next cycle ForwardAE=01. StallCnt=1, FlushCnt=1.
- RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 -> ForwardAE=10. With WriteRegM=0 and RsE=0 -> ForwardAE=00.
- MemtoRegM=1 with DmemReadyM low for 3 cycles, then high -> all four stalls and FlushW high for exactly 3 cycles, FlushE=0 throughout, back to RUN. A simultaneous lwstall is masked.
- MEM_TIMEOUT=4, DmemReadyM held low -> stall cycles end at the timeout (memstall deasserts when waitcnt reaches 4); MemErr=1 and stays 1 after later accesses.
- BranchD=1, PCSrcD=1, no dependencies -> FlushD=1 for one cycle. Then BranchD with RegWriteE=1, WriteRegE=RsD -> stall first, FlushD only once the dependency clears.
- Drive StallCnt to all-ones (CNT_W=4: 15 stalls then 1 more) -> stays 15. Pulse CntClr -> 0 next cycle. reset low mid-MEM_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: bypass selects,
// sequencing states and the hardwired-zero register number.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer only matters when it writes a real register; $0 never carries data.
  function automatic logic reg_match(input logic       we,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: bypass selects,
// load-use/branch stalls, memory-wait freeze with watchdog, perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic             DmemReadyM,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  ctrl_state_e     state_q, state_d;
  logic [WC_W-1:0] waitcnt_q, waitcnt_d;
  logic            memerr_q, memerr_d;

  logic     mem_acc, lwstall, brstall, memstall;
  fwd_sel_e fwd_ae, fwd_be;

  assign mem_acc = MemtoRegM | MemWriteM;

  assign lwstall = reg_match(MemtoRegE, RtE, RsD) | reg_match(MemtoRegE, RtE, RtD);

  assign brstall = BranchD &
                   (reg_match(RegWriteE, WriteRegE, RsD) | reg_match(RegWriteE, WriteRegE, RtD) |
                    reg_match(MemtoRegM, WriteRegM, RsD) | reg_match(MemtoRegM, WriteRegM, RtD));

  // The access cycle itself stalls in RUN; MEM_WAIT keeps stalling until ready or watchdog.
  assign memstall = ((state_q == ST_RUN) && mem_acc && !DmemReadyM) ||
                    ((state_q == ST_MEM_WAIT) && !DmemReadyM && (waitcnt_q < WC_MAX));

  always_comb begin
    fwd_ae = FWD_RF;
    if (reg_match(RegWriteM, WriteRegM, RsE))      fwd_ae = FWD_M;
    else if (reg_match(RegWriteW, WriteRegW, RsE)) fwd_ae = FWD_W;
    fwd_be = FWD_RF;
    if (reg_match(RegWriteM, WriteRegM, RtE))      fwd_be = FWD_M;
    else if (reg_match(RegWriteW, WriteRegW, RtE)) fwd_be = FWD_W;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      ForwardAD = reg_match(RegWriteM, WriteRegM, RsD);
      ForwardBD = reg_match(RegWriteM, WriteRegM, RtD);
      ForwardAE = fwd_ae;
      ForwardBE = fwd_be;
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (lwstall || brstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSrcD || JumpD) begin
        FlushD = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    memerr_d  = memerr_q;
    case (state_q)
      ST_RUN: begin
        if (mem_acc && !DmemReadyM) begin
          state_d   = ST_MEM_WAIT;
          waitcnt_d = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (DmemReadyM) begin
          state_d   = ST_RUN;
          waitcnt_d = '0;
        end else if (waitcnt_q < WC_MAX) begin
          waitcnt_d = waitcnt_q + WC_W'(1);
        end else begin
          state_d   = ST_RUN;
          waitcnt_d = '0;
          memerr_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_RUN;
        waitcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      waitcnt_q <= '0;
      memerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      memerr_q  <= memerr_d;
    end
  end

  assign MemErr = memerr_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .reset (reset),
    .inc_i (StallF),
    .clr_i (CntClr),
    .cnt_o (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .reset (reset),
    .inc_i (FlushD | FlushE),
    .clr_i (CntClr),
    .cnt_o (FlushCnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and 4-bit counters.
module tb_pipe_hazard_ctrl;

  logic       CLK, reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic       BranchD, PCSrcD, JumpD, DmemReadyM, CntClr;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemErr;
  logic [3:0] StallCnt, FlushCnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .CLK(CLK), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .DmemReadyM(DmemReadyM), .CntClr(CntClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0;
    DmemReadyM = 1; CntClr = 0;
  endtask

  task automatic set_lw();
    MemtoRegE = 1; RegWriteE = 1; RtE = 2; WriteRegE = 2; RsD = 2;
  endtask

  initial begin
    clr_in();
    reset = 1'b0;
    set_lw();
    #2;
    chk("rst_stallF", StallF, 0);
    chk("rst_flushE", FlushE, 0);
    chk("rst_memerr", MemErr, 0);
    chk("rst_stallcnt", StallCnt, 0);
    chk("rst_flushcnt", FlushCnt, 0);
    clr_in();
    tick();
    reset = 1'b1;
    tick();

    // load-use stall, then W bypass
    set_lw();
    #2;
    chk("lw_stallF", StallF, 1);
    chk("lw_stallD", StallD, 1);
    chk("lw_flushE", FlushE, 1);
    chk("lw_stallE", StallE, 0);
    chk("lw_flushD", FlushD, 0);
    tick();
    clr_in();
    RsE = 2; RegWriteW = 1; WriteRegW = 2;
    #2;
    chk("lw_fwdAE_W", ForwardAE, 2'b01);
    chk("lw_stallF_off", StallF, 0);
    chk("lw_stallcnt", StallCnt, 1);
    chk("lw_flushcnt", FlushCnt, 1);
    tick();

    // M over W priority and register zero
    clr_in();
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5; RsD = 5;
    #2;
    chk("fwdAE_M", ForwardAE, 2'b10);
    chk("fwdBE_M", ForwardBE, 2'b10);
    chk("fwdAD", ForwardAD, 1);
    chk("fwdBD", ForwardBD, 0);
    tick();
    WriteRegM = 0; WriteRegW = 0; RsE = 0; RtE = 0; RsD = 0;
    #2;
    chk("fwdAE_r0", ForwardAE, 2'b00);
    chk("fwdAD_r0", ForwardAD, 0);
    tick();

    // clear beats a simultaneous increment
    clr_in();
    set_lw();
    CntClr = 1;
    tick();
    clr_in();
    #2;
    chk("clr_stallcnt", StallCnt, 0);
    chk("clr_flushcnt", FlushCnt, 0);
    tick();

    // 3-cycle memory wait with a masked load-use stall
    clr_in();
    set_lw();
    MemtoRegM = 1; DmemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mw_stallF", StallF, 1);
      chk("mw_stallM", StallM, 1);
      chk("mw_flushW", FlushW, 1);
      chk("mw_flushE", FlushE, 0);
      tick();
    end
    DmemReadyM = 1;
    #2;
    chk("mw_rel_stallM", StallM, 0);
    chk("mw_rel_flushW", FlushW, 0);
    chk("mw_rel_lw_flushE", FlushE, 1);
    tick();
    clr_in();
    MemtoRegM = 1;
    #2;
    chk("zero_wait_stall", StallF, 0);
    chk("mw_stallcnt", StallCnt, 4);
    chk("mw_flushcnt", FlushCnt, 1);
    tick();

    // watchdog: 4 stall cycles, released on the 5th, MemErr afterwards
    clr_in();
    MemtoRegM = 1; DmemReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("to_stallM", StallM, 1);
      chk("to_memerr_pre", MemErr, 0);
      tick();
    end
    #2;
    chk("to_release", StallM, 0);
    chk("to_memerr_pending", MemErr, 0);
    tick();
    clr_in();
    #2;
    chk("to_memerr", MemErr, 1);
    chk("to_stallcnt", StallCnt, 8);
    tick();

    // back-to-back accesses each re-enter the wait state
    for (int k = 0; k < 2; k++) begin
      clr_in();
      MemWriteM = 1; DmemReadyM = 0;
      #2;
      chk("b2b_stall", StallE, 1);
      tick();
      DmemReadyM = 1;
      #2;
      chk("b2b_ready", StallE, 0);
      tick();
    end
    clr_in();
    #2;
    chk("b2b_memerr_sticky", MemErr, 1);
    chk("b2b_stallcnt", StallCnt, 10);
    tick();

    // branches
    clr_in();
    BranchD = 1; PCSrcD = 1; RsD = 3; RtD = 4;
    #2;
    chk("br_flushD", FlushD, 1);
    chk("br_stallF", StallF, 0);
    chk("br_flushE", FlushE, 0);
    tick();
    RegWriteE = 1; WriteRegE = 3;
    #2;
    chk("brE_stallF", StallF, 1);
    chk("brE_flushE", FlushE, 1);
    chk("brE_flushD", FlushD, 0);
    tick();
    RegWriteE = 0;
    #2;
    chk("brE_clear_flushD", FlushD, 1);
    tick();
    clr_in();
    BranchD = 1; MemtoRegM = 1; WriteRegM = 4; RtD = 4;
    #2;
    chk("brM_stallD", StallD, 1);
    chk("brM_stallM", StallM, 0);
    tick();
    clr_in();
    BranchD = 1; RegWriteE = 1; WriteRegE = 0; MemtoRegE = 1; RtE = 0;
    JumpD = 1;
    #2;
    chk("r0_no_stall", StallF, 0);
    chk("r0_jump_flushD", FlushD, 1);
    tick();
    clr_in();
    #2;
    chk("br_stallcnt", StallCnt, 12);
    chk("br_flushcnt", FlushCnt, 6);
    tick();

    // saturation
    CntClr = 1;
    tick();
    clr_in();
    set_lw();
    for (int i = 0; i < 15; i++) tick();
    #2;
    chk("sat_reach", StallCnt, 15);
    tick();
    clr_in();
    #2;
    chk("sat_hold_stall", StallCnt, 15);
    chk("sat_hold_flush", FlushCnt, 15);
    CntClr = 1;
    tick();
    CntClr = 0;
    #2;
    chk("sat_clr", StallCnt, 0);
    tick();

    // asynchronous reset during a memory wait
    clr_in();
    MemtoRegM = 1; DmemReadyM = 0;
    tick();
    set_lw();
    RegWriteM = 1; WriteRegM = 5; RsE = 5;
    #2;
    chk("rstmw_pre_stall", StallM, 1);
    chk("rstmw_pre_fwd", ForwardAE, 2'b10);
    reset = 1'b0;
    #1;
    chk("rstmw_stallF", StallF, 0);
    chk("rstmw_stallM", StallM, 0);
    chk("rstmw_flushW", FlushW, 0);
    chk("rstmw_fwdAE", ForwardAE, 2'b00);
    chk("rstmw_memerr", MemErr, 0);
    chk("rstmw_stallcnt", StallCnt, 0);
    clr_in();
    tick();
    reset = 1'b1;
    MemtoRegM = 1; DmemReadyM = 0;
    tick();
    // a fresh access from RUN gets the full four stall cycles
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("post_rst_wait", StallM, 1);
      tick();
    end
    #2;
    chk("post_rst_timeout", StallM, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
